// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: front end for the 32x3 RAM.
// Turns a raw active-low key into one synchronized write strobe that
// captures the switch address and data. It also scans the read address
// upward once every TICK_CYCLES clocks.
// Optional build macro RAM_PORT_CTRL_PAUSE_EN adds a 'pause' input that
// freezes the read scan. The write path is not affected by it.
module ram_port_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 3,
  parameter int TICK_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
`ifdef RAM_PORT_CTRL_PAUSE_EN
  input  logic              pause,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_tick,
  output logic              collide
);

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  // Key synchronizer chain plus the previous synchronized value for edge detect.
  logic             s1, s2, prev;
  logic [CNT_W-1:0] tick_cnt;

  // Next-state values. collide is computed from these so that it compares
  // the values the write and read ports will actually carry next cycle.
  logic              press;
  logic              scan_en;
  logic              wrap;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [CNT_W-1:0]  tick_cnt_nxt;

`ifdef RAM_PORT_CTRL_PAUSE_EN
  assign scan_en = ~pause;
`else
  assign scan_en = 1'b1;
`endif

  // Press edge, captured write fields, scan step and the collision compare.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned, which would infer a latch.
    press        = 1'b0;
    wrap         = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    rd_addr_nxt  = rd_addr;
    tick_cnt_nxt = tick_cnt;

    press = ~s2 & prev;
    if (press) begin
      wr_addr_nxt = sw_addr;
      wr_data_nxt = sw_data;
    end

    if (scan_en) begin
      if (tick_cnt == TICK_LAST) begin
        wrap         = 1'b1;
        tick_cnt_nxt = '0;
        rd_addr_nxt  = rd_addr + 1'b1;
      end else begin
        tick_cnt_nxt = tick_cnt + 1'b1;
      end
    end
  end

  // Register all state. The reset is synchronous and active-high.
  // A reset loads the key chain with "pressed", so a key that is held
  // through reset never produces a write.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register in this block samples pre-edge values and the s1->s2->prev chain really shifts by one stage per clock.
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
      rd_tick  <= 1'b0;
      collide  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      s1       <= key_n;
      s2       <= s1;
      prev     <= s2;
      wr_en    <= press;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      rd_addr  <= rd_addr_nxt;
      rd_tick  <= wrap;
      collide  <= press && (wr_addr_nxt == rd_addr_nxt);
      tick_cnt <= tick_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: scoreboard bench for ram_port_ctrl with TICK_CYCLES=4.
// Stimulus tasks push the expected write strobes and read steps, each
// stamped with the cycle (edges since reset release) where it must appear.
// A negedge monitor pops an entry whenever wr_en or rd_tick is high and
// compares it with the DUT outputs.
module tb_ram_port_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int TICK   = 4;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              col;
  } wr_exp_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              key_n;
  logic [ADDR_W-1:0] sw_addr;
  logic [DATA_W-1:0] sw_data;
  logic              pause;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_tick;
  logic              collide;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  int      cyc = 0;
  int      tests = 0;
  int      fails = 0;

  ram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_CYCLES(TICK)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .sw_addr (sw_addr),
    .sw_data (sw_data),
`ifdef RAM_PORT_CTRL_PAUSE_EN
    .pause   (pause),
`endif
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_tick (rd_tick),
    .collide (collide)
  );

  always #5 clk = ~clk;

  // Cycle stamp: the number of edges since reset was released.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every strobe, and keep collide low otherwise.
  always @(negedge clk) begin
    if (rd_tick === 1'b1) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: rd_tick at cycle %0d, rd_addr %0h, none expected", cyc, rd_addr);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
        check("rd_addr", 32'(rd_addr), 32'(e.addr));
      end
    end
    if (wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: wr_en at cycle %0d, wr_addr %0h, none expected", cyc, wr_addr);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        check("wr_cycle", 32'(cyc), 32'(w.cyc));
        check("wr_addr", 32'(wr_addr), 32'(w.addr));
        check("wr_data", 32'(wr_data), 32'(w.data));
        check("collide", 32'(collide), 32'(w.col));
      end
    end else begin
      check("collide_idle", 32'(collide), 32'h0);
    end
  end

  // Wait until the cycle stamp reaches c, then step just past the negedge.
  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic push_rd(input int c, input int a);
    rd_exp_t e;
    e.cyc  = c;
    e.addr = ADDR_W'(a);
    rd_q.push_back(e);
  endtask

  // Drive key low from cycle c until cycle rel; the strobe is expected at c+3.
  task automatic press(input int c, input int rel, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic col);
    wr_exp_t w;
    at_cycle(c);
    sw_addr = a;
    sw_data = d;
    key_n   = 1'b0;
    w.cyc   = c + 3;
    w.addr  = a;
    w.data  = d;
    w.col   = col;
    wr_q.push_back(w);
    at_cycle(rel);
    key_n = 1'b1;
  endtask

  task automatic check_reset_state();
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_rd_tick", 32'(rd_tick), 32'h0);
    check("rst_collide", 32'(collide), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    key_n   = 1'b1;
    sw_addr = '0;
    sw_data = '0;
    pause   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    #1 reset = 1'b0;

    // First run: the scan steps every 4 edges and wraps 31 -> 0 at cycle 128.
    for (int n = 1; n <= 38; n++) push_rd(4 * n, n % 32);

    // A long press produces one strobe at cycle 17. rd_addr is 4 then, so no collide.
    press(14, 34, 5'h0A, 3'b101, 1'b0);
    at_cycle(40);
    check("hold_wr_addr", 32'(wr_addr), 32'h0A);
    check("hold_wr_data", 32'(wr_data), 32'h5);

    // Strobe at 140 coincides with the step to rd_addr 3; the address is 4, so no collide.
    press(137, 138, 5'h04, 3'b110, 1'b0);
    // Strobe at 143 has address 3 while rd_addr is 3, so collide is set.
    press(140, 142, 5'h03, 3'b011, 1'b1);
    at_cycle(146);
    check("wrap_seen_rd_addr", 32'(rd_addr), 32'h4);

    // The key falls at 150. Reset at edge 153 aborts the pending strobe.
    at_cycle(150);
    key_n = 1'b0;
    at_cycle(152);
    reset = 1'b1;
    rd_q.delete();
    repeat (3) @(negedge clk);
    check_reset_state();
    #1 reset = 1'b0;

    // Second run. The key stays low through release, so no strobe occurs.
    // A normal press later still works.
`ifdef RAM_PORT_CTRL_PAUSE_EN
    for (int n = 1; n <= 6; n++) push_rd(4 * n, n);
    push_rd(38, 7);
    push_rd(42, 8);
    push_rd(46, 9);
`else
    for (int n = 1; n <= 11; n++) push_rd(4 * n, n);
`endif
    at_cycle(10);
    key_n = 1'b1;
    press(20, 25, 5'h1F, 3'b111, 1'b0);
`ifdef RAM_PORT_CTRL_PAUSE_EN
    // Pause starts with tick_cnt at 2 and lasts 10 edges. The next step comes 2 edges after release.
    at_cycle(26);
    pause = 1'b1;
`endif
    press(28, 30, 5'h12, 3'b010, 1'b0);
`ifdef RAM_PORT_CTRL_PAUSE_EN
    at_cycle(33);
    check("pause_rd_addr", 32'(rd_addr), 32'h6);
    at_cycle(36);
    pause = 1'b0;
`endif
    at_cycle(46);
    check("rd_q_empty", 32'(rd_q.size()), 32'h0);
    check("wr_q_empty", 32'(wr_q.size()), 32'h0);
    check("final_wr_addr", 32'(wr_addr), 32'h12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
